// File: rtl/div_rr_sched_if.sv
// Request/response bundle between the clients and the shared divider.
// The scheduler takes the slave side; the requesters and consumer take the master side.
interface div_rr_sched_if #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_dvd;
   logic [NREQ*WIDTH-1:0] req_dvs;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_qot;
   logic [WIDTH-1:0]      rsp_rmd;
   logic                  rsp_dbz;
   logic                  busy;

   modport master (
      output req_valid, req_dvd, req_dvs, rsp_ready,
      input  req_ready, rsp_valid, rsp_id,
      input  rsp_qot, rsp_rmd, rsp_dbz, busy
   );

   modport slave (
      input  req_valid, req_dvd, req_dvs, rsp_ready,
      output req_ready, rsp_valid, rsp_id,
      output rsp_qot, rsp_rmd, rsp_dbz, busy
   );
endinterface

// File: rtl/div_rr_sched.sv
// Round-robin scheduler around one restoring divider.
// Produces one quotient bit per clock and runs a single operation at a time.
module div_rr_sched #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input logic         clk,
   input logic         reset_n,
   div_rr_sched_if.slave bus
);
   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

   state_t           state;
   logic [IDW-1:0]   last;
   logic [IDW-1:0]   gid;
   logic             found;
   logic [NREQ-1:0]  gnt;
   logic [WIDTH:0]   acc;
   logic [WIDTH:0]   acc_sh;
   logic [WIDTH:0]   t;
   logic [WIDTH:0]   acc_nx;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_nx;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] dvd_g;
   logic [WIDTH-1:0] dvs_g;
   logic [CW-1:0]    cnt;

   // Search starts just past the last winner so every requester gets a turn.
   always_comb begin
      found = 1'b0;
      gid   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && bus.req_valid[(int'(last) + k) % NREQ]) begin
            found = 1'b1;
            gid   = IDW'((int'(last) + k) % NREQ);
         end
      end
      gnt = '0;
      if (found) gnt[gid] = 1'b1;
   end

   assign bus.req_ready = (reset_n && state == IDLE) ? gnt : '0;
   assign dvd_g = bus.req_dvd[gid*WIDTH +: WIDTH];
   assign dvs_g = bus.req_dvs[gid*WIDTH +: WIDTH];

   assign acc_sh = {acc[WIDTH-1:0], q[WIDTH-1]};
   assign t      = acc_sh - {1'b0, dvs};
   assign acc_nx = t[WIDTH] ? acc_sh : t;
   assign q_nx   = {q[WIDTH-2:0], ~t[WIDTH]};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= IDLE;
         last          <= IDW'(NREQ - 1);
         acc           <= '0;
         q             <= '0;
         dvs           <= '0;
         cnt           <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= '0;
         bus.rsp_qot   <= '0;
         bus.rsp_rmd   <= '0;
         bus.rsp_dbz   <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  last       <= gid;
                  bus.rsp_id <= gid;
                  acc        <= '0;
                  q          <= dvd_g;
                  dvs        <= dvs_g;
                  cnt        <= CW'(WIDTH);
                  bus.busy   <= 1'b1;
                  if (dvs_g == '0) begin
                     state         <= DONE;
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_qot   <= '1;
                     bus.rsp_rmd   <= dvd_g;
                     bus.rsp_dbz   <= 1'b1;
                  end else begin
                     state <= DIV;
                  end
               end
            end
            DIV: begin
               acc <= acc_nx;
               q   <= q_nx;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state         <= DONE;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_qot   <= q_nx;
                  bus.rsp_rmd   <= acc_nx[WIDTH-1:0];
                  bus.rsp_dbz   <= 1'b0;
               end
            end
            DONE: begin
               if (bus.rsp_ready) begin
                  state         <= IDLE;
                  bus.rsp_valid <= 1'b0;
                  bus.busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div_rr_sched.sv
// Bench for div_rr_sched: table of divisions, round-robin order,
// back-pressure in DONE and reset abort, checked through a scoreboard.
module tb_div_rr_sched;
   localparam int W = 8;
   localparam int N = 4;

   typedef struct {
      int         id;
      logic [7:0] dvd;
      logic [7:0] dvs;
      logic [7:0] q;
      logic [7:0] r;
      logic       dbz;
      int         lat;
   } vec_t;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] q;
      logic [7:0] r;
      logic       dbz;
   } exp_t;

   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_bad;
   exp_t sb[$];
   vec_t tbl[8];
   logic [7:0] a[N];
   logic [7:0] b[N];

   div_rr_sched_if #(.WIDTH(W), .NREQ(N)) bus ();

   div_rr_sched #(.WIDTH(W), .NREQ(N)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t model(input int id, input logic [7:0] x,
                                  input logic [7:0] y);
      exp_t e;
      e.id = 2'(id);
      if (y == 0) begin
         e.q = 8'hFF; e.r = x; e.dbz = 1'b1;
      end else begin
         e.q = x / y; e.r = x % y; e.dbz = 1'b0;
      end
      return e;
   endfunction

   task automatic set_ops(input int id, input logic [7:0] x,
                          input logic [7:0] y);
      bus.req_dvd[id*W +: W] = x;
      bus.req_dvs[id*W +: W] = y;
   endtask

   task automatic accept(input int id, input logic [7:0] x,
                         input logic [7:0] y, input exp_t e);
      int n;
      set_ops(id, x, y);
      bus.req_valid[id] = 1'b1;
      #1;
      n = 0;
      while (!bus.req_ready[id] && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (!bus.req_ready[id]) begin
         check("grant_timeout", 0, 1);
         bus.req_valid[id] = 1'b0;
         return;
      end
      check("ready_onehot", bus.req_ready, 32'(1) << id);
      sb.push_back(e);
      @(posedge clk); #1;
      bus.req_valid[id] = 1'b0;
      check("busy_after_accept", bus.busy, 1);
      check("ready_low_busy", bus.req_ready, 0);
   endtask

   task automatic get_rsp(input int lat, input int hold);
      int   n;
      exp_t e;
      logic [18:0] cap;
      n = 1;
      while (!bus.rsp_valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
      if (!bus.rsp_valid) begin
         check("rsp_timeout", 0, 1);
         return;
      end
      check("latency", n, lat);
      cap = {bus.rsp_id, bus.rsp_qot, bus.rsp_rmd, bus.rsp_dbz};
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("hold_valid", bus.rsp_valid, 1);
         check("hold_stable",
               {bus.rsp_id, bus.rsp_qot, bus.rsp_rmd, bus.rsp_dbz}, cap);
         check("hold_ready", bus.req_ready, 0);
      end
      if (sb.size() == 0) begin
         check("sb_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         check("rsp_id", bus.rsp_id, e.id);
         check("rsp_qot", bus.rsp_qot, e.q);
         check("rsp_rmd", bus.rsp_rmd, e.r);
         check("rsp_dbz", bus.rsp_dbz, e.dbz);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("rsp_drop", bus.rsp_valid, 0);
   endtask

   initial begin
      int   n;
      int   gid;
      int   seen;
      exp_t e;
      n_cmp = 0;
      n_bad = 0;
      tbl[0] = '{0, 8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9};
      tbl[1] = '{2, 8'd55,  8'd0,   8'hFF,  8'd55,  1'b1, 1};
      tbl[2] = '{1, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9};
      tbl[3] = '{3, 8'd3,   8'd200, 8'd0,   8'd3,   1'b0, 9};
      tbl[4] = '{0, 8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9};
      tbl[5] = '{1, 8'd200, 8'd3,   8'd66,  8'd2,   1'b0, 9};
      tbl[6] = '{2, 8'd255, 8'd0,   8'hFF,  8'd255, 1'b1, 1};
      tbl[7] = '{3, 8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9};

      reset_n       = 1'b0;
      bus.req_valid = '1;
      bus.req_dvd   = '0;
      bus.req_dvs   = '0;
      bus.rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", bus.req_ready, 0);
      check("rst_valid", bus.rsp_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_data",
            {bus.rsp_id, bus.rsp_qot, bus.rsp_rmd, bus.rsp_dbz}, 0);
      bus.req_valid = '0;
      reset_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         e = '{2'(tbl[i].id), tbl[i].q, tbl[i].r, tbl[i].dbz};
         accept(tbl[i].id, tbl[i].dvd, tbl[i].dvs, e);
         get_rsp(tbl[i].lat, 0);
      end

      for (int i = 0; i < N; i++) begin
         a[i] = 8'($urandom_range(0, 255));
         b[i] = 8'($urandom_range(0, 255));
         set_ops(i, a[i], b[i]);
      end
      bus.req_valid = '1;
      #1;
      for (int k = 0; k < 6; k++) begin
         n = 0;
         while (bus.req_ready == 0 && n < 20) begin
            @(posedge clk); #1; n++;
         end
         if (bus.req_ready == 0) begin
            check("rr_timeout", 0, 1);
            break;
         end
         check("rr_onehot", 32'($onehot(bus.req_ready)), 1);
         gid = 0;
         for (int i = 0; i < N; i++) if (bus.req_ready[i]) gid = i;
         check("rr_order", gid, k % N);
         sb.push_back(model(gid, a[gid], b[gid]));
         n = (b[gid] == 0) ? 1 : W + 1;
         @(posedge clk); #1;
         a[gid] = 8'($urandom_range(0, 255));
         b[gid] = 8'($urandom_range(1, 255));
         set_ops(gid, a[gid], b[gid]);
         get_rsp(n, 0);
      end
      bus.req_valid = '0;

      bus.rsp_ready = 1'b0;
      accept(1, 8'd77, 8'd9, model(1, 8'd77, 8'd9));
      set_ops(0, 8'd130, 8'd11);
      bus.req_valid[0] = 1'b1;
      get_rsp(W + 1, 5);
      check("resume_ready", bus.req_ready, 4'b0001);
      accept(0, 8'd130, 8'd11, model(0, 8'd130, 8'd11));
      get_rsp(W + 1, 0);

      accept(2, 8'd200, 8'd3, model(2, 8'd200, 8'd3));
      repeat (3) @(posedge clk);
      #1;
      bus.req_valid = 4'b1001;
      reset_n = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_ready", bus.req_ready, 0);
      check("rst_mid_busy", bus.busy, 0);
      reset_n = 1'b1;
      bus.req_valid = '0;
      void'(sb.pop_back());
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (bus.rsp_valid) seen++;
      end
      check("abort_no_rsp", seen, 0);
      bus.req_valid = 4'b1001;
      #1;
      check("post_rst_grant", bus.req_ready, 4'b0001);
      bus.req_valid = '0;
      accept(0, 8'd9, 8'd4, model(0, 8'd9, 8'd4));
      get_rsp(W + 1, 0);
      check("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
